// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the RV32I core: owns the PC, issues one
// imem request per instruction, holds the fetched word until it retires.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc,
  input  logic        pcsrc,
  input  logic        stall,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_exc,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        retire;
  logic        misaligned;
  logic [31:0] pc_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: if (imem_ready) state_nxt = ISSUE;
      ISSUE: begin
        // stall outranks halt_req; a pending halt is honoured at retire
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = halt_req ? HALT : FETCH;
        end
      end
      HALT:  if (!halt_req) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  assign pc_plus4   = pc + 32'd4;
  assign misaligned = pcsrc && (npc[1:0] != 2'b00);

  always_comb begin
    pc_nxt = pc_plus4;
    if (pcsrc) pc_nxt = misaligned ? TRAP_PC : npc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_exc <= 1'b0;
      instret      <= '0;
    end else begin
      misalign_exc <= retire && misaligned;
      if (state == FETCH && imem_ready) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        pc          <= pc_nxt;
        instret     <= instret + 32'd1;
      end
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected
// fetch addresses and retired (pc, instr) pairs; a monitor pops and compares.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] npc = '0;
  logic        pcsrc = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_exc;
  logic        halted;
  logic [31:0] instret;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .TRAP_PC (32'h0000_0100)
  ) dut (
    .clk(clk), .rstn(rstn), .npc(npc), .pcsrc(pcsrc), .stall(stall),
    .halt_req(halt_req), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_exc(misalign_exc), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned failed = 0;
  int unsigned cyc = 0;
  int unsigned lat = 0;
  int unsigned wcnt = 0;
  logic        force_rdy = 1'b0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_ret[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic push_retire(input logic [31:0] a);
    exp_ret.push_back({a, mem_word(a)});
  endtask

  always @(posedge clk) cyc++;

  // instruction memory: answers after lat wait cycles with mem_word(addr)
  always @(posedge clk) begin
    #2;
    if (force_rdy) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rstn) begin
      chk("req_and_valid_exclusive", {31'b0, imem_req & instr_valid}, 32'd0);
      if (imem_req && imem_ready) begin
        if (exp_addr.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_fetch: got addr %h expected no request", imem_addr);
        end else chk("fetch_addr", imem_addr, exp_addr.pop_front());
      end
      if (instr_valid && !stall) begin
        if (exp_ret.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_retire: got pc %h expected no retire", pc);
        end else begin
          logic [63:0] e;
          e = exp_ret.pop_front();
          chk("retire_pc", pc, e[63:32]);
          chk("retire_instr", instr, e[31:0]);
        end
      end
    end
  end

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    tests++; failed++;
    $display("FAIL wait_valid_timeout: got no instr_valid expected within 50 cycles");
  endtask

  task automatic go(input logic ps, input logic [31:0] np, input logic hr);
    wait_valid();
    @(posedge clk); #1;
    stall = 1'b0; pcsrc = ps; npc = np; halt_req = hr;
    @(posedge clk); #1;
    stall = 1'b1; pcsrc = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_misalign"}, {31'b0, misalign_exc}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
  endtask

  initial begin
    int unsigned t[3];
    int unsigned reqcnt;

    #3 rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("boot_no_req", {31'b0, imem_req}, 32'd0);

    // sequential fetch, free running
    for (int i = 0; i < 3; i++) begin
      push_fetch(32'(4 * i));
      push_retire(32'(4 * i));
    end
    push_fetch(32'h0C);
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      t[i] = cyc;
    end
    chk("cadence_1", t[1] - t[0], 32'd2);
    chk("cadence_2", t[2] - t[1], 32'd2);
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    chk("instret_after_3", instret, 32'd3);

    // stall hold in ISSUE
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, 32'h0C);
      chk("stall_instr", instr, mem_word(32'h0C));
      chk("stall_instret", instret, 32'd3);
    end
    push_retire(32'h0C); push_fetch(32'h10);
    go(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("instret_after_stall", instret, 32'd4);

    // redirect aligned, then misaligned
    push_retire(32'h10); push_fetch(32'h40);
    go(1'b1, 32'h40, 1'b0);
    @(negedge clk);
    chk("redirect_misalign", {31'b0, misalign_exc}, 32'd0);
    chk("redirect_pc", pc, 32'h40);
    push_retire(32'h40); push_fetch(32'h100);
    go(1'b1, 32'h42, 1'b0);
    @(negedge clk);
    chk("trap_misalign_pulse", {31'b0, misalign_exc}, 32'd1);
    chk("trap_pc", pc, 32'h100);
    @(negedge clk);
    chk("trap_misalign_drop", {31'b0, misalign_exc}, 32'd0);

    // slow memory: 3 wait cycles
    lat = 3;
    push_retire(32'h100); push_fetch(32'h104);
    go(1'b0, '0, 1'b0);
    reqcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) break;
      if (imem_req) begin
        reqcnt++;
        chk("slow_addr_stable", imem_addr, 32'h104);
      end
    end
    chk("slow_req_cycles", reqcnt, 32'd4);
    chk("slow_instr", instr, mem_word(32'h104));
    lat = 0;

    // halt at pc 0x20
    push_retire(32'h104); push_fetch(32'h20);
    go(1'b1, 32'h20, 1'b0);
    push_retire(32'h20);
    go(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h24);
    chk("halt_no_req", {31'b0, imem_req}, 32'd0);
    chk("halt_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_instret", instret, 32'd9);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("halt_hold", {30'b0, halted, imem_req}, 32'd2);
    end
    @(posedge clk); #1 halt_req = 1'b0;
    push_fetch(32'h24);
    @(negedge clk);
    chk("halt_still_set", {31'b0, halted}, 32'd1);
    @(negedge clk);
    chk("resume_halted", {31'b0, halted}, 32'd0);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h24);

    // reset in the middle of a stalled fetch
    push_retire(32'h24);
    lat = 10;
    go(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0; force_rdy = 1'b1; lat = 0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset_rdy");
    @(posedge clk); #1;
    rstn = 1'b1; force_rdy = 1'b0;
    @(negedge clk);
    chk("rerelease_boot_req", {31'b0, imem_req}, 32'd0);
    chk("rerelease_valid", {31'b0, instr_valid}, 32'd0);
    push_fetch(32'h0);
    wait_valid();
    chk("restart_pc", pc, 32'h0);
    chk("restart_instr", instr, mem_word(32'h0));
    chk("restart_instret", instret, 32'd0);

    // pc wrap at the top of the address space
    push_retire(32'h0); push_fetch(32'hFFFF_FFFC);
    go(1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_valid();
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    push_retire(32'hFFFF_FFFC); push_fetch(32'h0);
    go(1'b0, '0, 1'b0);
    wait_valid();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'd2);

    repeat (2) @(negedge clk);
    chk("fetch_queue_drained", exp_addr.size(), 32'd0);
    chk("retire_queue_drained", exp_ret.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the RV32I core.
- Issues one request per instruction to instruction memory over a req/ready handshake and holds the fetched word for decode.
- Selects the next PC as the branch/jump target or PC+4 when the instruction retires.
- Adds stall, halt and misaligned-target trap control, plus a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded when a redirect target is misaligned.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- npc  in  32  branch/jump target from the datapath.
- pcsrc  in  1  1 = take npc at retire, 0 = take PC+4.
- stall  in  1  datapath not ready to retire the current instruction.
- halt_req  in  1  request to stop fetching after the current instruction.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  instruction memory returns data this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction for decode.
- instr_valid  out  1  instr is valid and awaiting retire.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, combinational.
- misalign_exc  out  1  one-cycle pulse on a misaligned redirect.
- halted  out  1  sequencer is in HALT.
- instret  out  32  count of retired instructions.

Behaviour:
Reset (asynchronous, rstn=0):
- State BOOT, pc=RESET_PC.
- imem_req=0, instr=0, instr_valid=0, misalign_exc=0, halted=0, instret=0.
- Reset asserted mid-fetch abandons the fetch; any late imem_ready is ignored.

States:
- BOOT: imem_req=0. Always goes to FETCH next cycle, so the first request appears on the 2nd clock edge after rstn rises.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to ISSUE.
  - Otherwise stay; wait is unbounded.
  - pcsrc, stall and halt_req are ignored in this state.
  - Minimum latency: request cycle to instr_valid is 1 cycle.
- ISSUE:
  - imem_req=0, instr_valid=1.
  - stall=1: hold everything; instr and pc are stable.
  - stall=0 (retire): instret<=instret+1, wrapping 32'hFFFF_FFFF->0; instr_valid<=0.
  - Next PC at retire:
    - pcsrc=0: pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
    - pcsrc=1 and npc[1:0]==0: pc<=npc.
    - pcsrc=1 and npc[1:0]!=0: pc<=TRAP_PC, misalign_exc=1 for exactly that next cycle. The trapping instruction still counts in instret.
  - Next state at retire: HALT if halt_req=1, otherwise FETCH.
  - stall and halt_req asserted together: stall wins; the halt takes effect at the eventual retire if halt_req is still high.
- HALT:
  - halted=1, imem_req=0, instr_valid=0; pc holds the next instruction address.
  - halt_req=0: go to FETCH next cycle, halted drops to 0.
- imem_req and instr_valid are never high in the same cycle.
- pc changes only at retire or reset.

Test Plan:
1. Reset then imem_ready tied 1 with rdata=32'h00000013, stall=0, pcsrc=0 -> requests at pc 0x0, 0x4, 0x8. Each instruction takes 2 cycles (FETCH, ISSUE). instret=3 after the third retire.
2. imem_ready delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable, then instr_valid=1 the next cycle with instr equal to rdata.
3. In ISSUE at pc=0x10, pcsrc=1, npc=0x40 -> next imem_addr=0x40, no misalign_exc. Repeat with npc=0x42 -> pc=TRAP_PC (0x100) and misalign_exc pulses exactly 1 cycle.
4. stall=1 for 5 cycles in ISSUE -> instr, pc and instr_valid stable, instret unchanged. Retire on the first stall=0 cycle.
5. halt_req=1 in ISSUE at pc=0x20 with stall=0 -> halted=1, pc=0x24, no imem_req. Deassert halt_req -> fetch from 0x24 on the next cycle.
6. rstn pulsed low mid-FETCH with imem_ready arriving during reset -> all outputs at reset values and instr_valid stays 0. Fetch restarts at RESET_PC after BOOT.
